io_out_arb: RTL and testbench

IO_OUT_ARB -- requirements
Module: io_out_arb

---
 rtl/io_out_arb.sv | 205 ++++++++++++++++++++
 tb/tb_io_out_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_out_arb.sv
// io_out_arb: two requesters arbitrated into a word FIFO that drains through a 4-phase req/ack handshake.
// Optional handshake timeout (sticky err, word dropped) is compiled in when IO_OUT_TIMEOUT_EN is defined.
module io_out_arb #(
  parameter int WORD_SIZE      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr0_valid,
  input  logic [WORD_SIZE-1:0] wr0_data,
  output logic                 wr0_ready,
  input  logic                 wr1_valid,
  input  logic [WORD_SIZE-1:0] wr1_data,
  output logic                 wr1_ready,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("io_out_arb: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [WORD_SIZE-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wptr_r;
  logic [PW-1:0]        rptr_r;
  logic [CW-1:0]        count_r;
  logic                 last_grant_r;
  state_t               state_r;
  state_t               state_nx_s;
  logic [WORD_SIZE-1:0] out_data_r;
  logic                 out_req_r;
  logic                 full_s;
  logic                 rdy0_s;
  logic                 rdy1_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 timeout_hit_s;
  logic [WORD_SIZE-1:0] push_data_s;

  assign full_s = (count_r == DEPTH_C);

  // Arbitration: a tie goes to the requester that was not granted last.
  always_comb begin
    rdy0_s = 1'b0;
    rdy1_s = 1'b0;
    if (!rst_n || full_s) begin
      rdy0_s = 1'b0;
      rdy1_s = 1'b0;
    end else if (wr0_valid && wr1_valid) begin
      rdy0_s = last_grant_r;
      rdy1_s = !last_grant_r;
    end else begin
      rdy0_s = wr0_valid;
      rdy1_s = wr1_valid;
    end
  end

  // Push selection: at most one requester can be ready at a time.
  always_comb begin
    push_s      = (wr0_valid && rdy0_s) || (wr1_valid && rdy1_s);
    push_data_s = {WORD_SIZE{1'b0}};
    if (wr1_valid && rdy1_s) begin
      push_data_s = wr1_data;
    end else begin
      push_data_s = wr0_data;
    end
  end

  // FIFO storage, pointers, occupancy and grant history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WORD_SIZE{1'b0}};
      end
      wptr_r       <= {PW{1'b0}};
      rptr_r       <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      last_grant_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= push_data_s;
        wptr_r        <= wptr_r + PW'(1'b1);
        last_grant_r  <= wr1_valid && rdy1_s;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Handshake next-state: ack is honoured before any timeout in the same cycle.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != {CW{1'b0}}) begin
          pop_s      = 1'b1;
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (out_ack) begin
          state_nx_s = ST_REL;
        end else if (timeout_hit_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_REL: begin
        if (!out_ack) begin
          state_nx_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_REL;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Handshake state, registered request and the word held for the device.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      out_req_r  <= 1'b0;
      out_data_r <= {WORD_SIZE{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      out_req_r <= (state_nx_s == ST_REQ);
      if (pop_s) begin
        out_data_r <= mem_r[rptr_r];
      end
    end
  end

`ifdef IO_OUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST_C = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] phase_cnt_r;
  logic          err_r;

  // Phase dwell counter: restarts on every state change, counts time spent in REQ or REL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_r <= {TW{1'b0}};
    end else if (state_r == ST_IDLE || state_nx_s != state_r) begin
      phase_cnt_r <= {TW{1'b0}};
    end else begin
      phase_cnt_r <= phase_cnt_r + TW'(1'b1);
    end
  end

  assign timeout_hit_s = (state_r != ST_IDLE) && (phase_cnt_r == TO_LAST_C);

  // Sticky error: set only when the phase expires without the expected ack level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (timeout_hit_s && ((state_r == ST_REQ && !out_ack) || (state_r == ST_REL && out_ack))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign err           = 1'b0;
`endif

  assign wr0_ready = rdy0_s;
  assign wr1_ready = rdy1_s;
  assign out_req   = out_req_r;
  assign out_data  = out_data_r;
  assign busy      = (count_r != {CW{1'b0}}) || (state_r != ST_IDLE);

endmodule

// File: tb/tb_io_out_arb.sv
// Directed self-checking bench for io_out_arb; one task per scenario, each with inline checks.
// With IO_OUT_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8 and the timeout scenario runs.
module tb_io_out_arb;

  localparam int WS    = 8;
  localparam int DEPTH = 4;
`ifdef IO_OUT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr0_valid = 1'b0;
  logic [WS-1:0] wr0_data = 8'h00;
  logic          wr0_ready;
  logic          wr1_valid = 1'b0;
  logic [WS-1:0] wr1_data = 8'h00;
  logic          wr1_ready;
  logic          out_req;
  logic          out_ack;
  logic [WS-1:0] out_data;
  logic          busy;
  logic          err;

  logic ack_tie = 1'b0;
  logic ack_man = 1'b0;
  assign out_ack = ack_tie ? out_req : ack_man;

  int tests = 0;
  int fails = 0;

  io_out_arb #(
    .WORD_SIZE(WS),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr0_valid(wr0_valid),
    .wr0_data(wr0_data),
    .wr0_ready(wr0_ready),
    .wr1_valid(wr1_valid),
    .wr1_data(wr1_data),
    .wr1_ready(wr1_ready),
    .out_req(out_req),
    .out_ack(out_ack),
    .out_data(out_data),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Output monitor: logs each presented word and its cycle, and flags data changing mid-handshake.
  logic [WS-1:0] obs[$];
  int            rise_q[$];
  int            cyc = 0;
  int            stab_err = 0;
  logic          prev_req = 1'b0;
  logic [WS-1:0] held = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_req && !prev_req) begin
      obs.push_back(out_data);
      rise_q.push_back(cyc);
      held <= out_data;
    end else if ((out_req || out_ack) && out_data !== held) begin
      stab_err <= stab_err + 1;
    end
    prev_req <= out_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    wr0_data  = 8'h00;
    wr1_data  = 8'h00;
    ack_tie   = 1'b0;
    ack_man   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ack_tie   = 1'b0;
    ack_man   = 1'b0;
    wr0_valid = 1'b1;
    wr1_valid = 1'b1;
    wr0_data  = 8'h11;
    wr1_data  = 8'h22;
    repeat (2) @(posedge clk);
    #2;
    tests++; if (out_req !== 1'b0) begin fails++; $display("FAIL reset_out_req: got %b want 0", out_req); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    tests++; if (wr0_ready !== 1'b0 || wr1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b%b want 00", wr0_ready, wr1_ready);
    end
    rst_n = 1'b1;
    #1;
    tests++; if (wr0_ready !== 1'b1 || wr1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_first_tie: got r0=%b r1=%b want r0=1 r1=0", wr0_ready, wr1_ready);
    end
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    ack_tie   = 1'b1;
    wr0_valid = 1'b1;
    wr0_data  = 8'h41;
    #1;
    tests++; if (wr0_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", wr0_ready); end
    tick();
    wr0_valid = 1'b0;
    tests++; if (out_req !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_E: got req=%b busy=%b want req=0 busy=1", out_req, busy);
    end
    tick();
    tests++; if (out_req !== 1'b1 || out_data !== 8'h41) begin
      fails++; $display("FAIL single_E1: got req=%b data=%h want req=1 data=41", out_req, out_data);
    end
    tick();
    tests++; if (out_req !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_E2: got req=%b busy=%b want req=0 busy=1", out_req, busy);
    end
    tick();
    tests++; if (busy !== 1'b0 || out_data !== 8'h41) begin
      fails++; $display("FAIL single_E3: got busy=%b data=%h want busy=0 data=41", busy, out_data);
    end
  endtask

  task automatic test_contention();
    int i0 = 0;
    int i1 = 0;
    int n = 0;
    int base;
    logic a0, a1;
    logic [WS-1:0] exp_v, got_v;
    do_reset();
    ack_tie = 1'b1;
    base = obs.size();
    while ((i0 < 8 || i1 < 8) && n < 300) begin
      wr0_valid = (i0 < 8);
      wr0_data  = 8'h30 + 8'(i0);
      wr1_valid = (i1 < 8);
      wr1_data  = 8'h60 + 8'(i1);
      #1;
      a0 = wr0_ready;
      a1 = wr1_ready;
      tests++; if (a0 && a1) begin fails++; $display("FAIL contention_one_grant: got r0=1 r1=1 want at most one"); end
      tick();
      if (a0) i0++;
      if (a1) i1++;
      n++;
    end
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    tests++; if (i0 != 8 || i1 != 8) begin fails++; $display("FAIL contention_accept: got %0d/%0d want 8/8", i0, i1); end
    n = 0;
    while (obs.size() < base + 16 && n < 300) begin tick(); n++; end
    tests++; if (obs.size() != base + 16) begin fails++; $display("FAIL contention_count: got %0d want 16", obs.size() - base); end
    for (int k = 0; k < 16; k++) begin
      exp_v = (k % 2 == 0) ? 8'h30 + 8'(k / 2) : 8'h60 + 8'(k / 2);
      got_v = (base + k < obs.size()) ? obs[base + k] : 8'hxx;
      tests++; if (got_v !== exp_v) begin fails++; $display("FAIL contention_order[%0d]: got %h want %h", k, got_v, exp_v); end
    end
  endtask

  task automatic test_full();
    int n = 0;
    int base;
    logic [WS-1:0] got_v;
    do_reset();
    ack_tie = 1'b0;
    ack_man = 1'b0;
    base = obs.size();
    // One word sits in the output register, four more fill the FIFO; the sixth must stall.
    for (int k = 0; k < 6; k++) begin
      wr0_valid = 1'b1;
      wr0_data  = 8'hA0 + 8'(k);
      #1;
      tests++; if (wr0_ready !== (k < 5)) begin fails++; $display("FAIL full_ready[%0d]: got %b want %b", k, wr0_ready, (k < 5)); end
      tick();
    end
    wr0_valid = 1'b0;
    tests++; if (out_req !== 1'b1 || out_data !== 8'hA0 || busy !== 1'b1) begin
      fails++; $display("FAIL full_hold: got req=%b data=%h busy=%b want 1/a0/1", out_req, out_data, busy);
    end
`ifndef IO_OUT_TIMEOUT_EN
    repeat (20) tick();
    tests++; if (out_req !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL full_wait_forever: got req=%b err=%b want req=1 err=0", out_req, err);
    end
`endif
    ack_tie = 1'b1;
    while ((obs.size() < base + 5 || busy) && n < 300) begin tick(); n++; end
    repeat (4) tick();
    tests++; if (obs.size() != base + 5) begin fails++; $display("FAIL full_count: got %0d want 5", obs.size() - base); end
    for (int k = 0; k < 5; k++) begin
      got_v = (base + k < obs.size()) ? obs[base + k] : 8'hxx;
      tests++; if (got_v !== 8'hA0 + 8'(k)) begin fails++; $display("FAIL full_order[%0d]: got %h want %h", k, got_v, 8'hA0 + 8'(k)); end
    end
  endtask

  task automatic test_slow_device();
    int i1 = 0;
    int n = 0;
    int dly = 0;
    int base;
    int s0;
    logic a1;
    logic [WS-1:0] got_v;
    do_reset();
    base = obs.size();
    s0 = stab_err;
    while (!(i1 == 3 && obs.size() == base + 3 && !busy && !ack_man) && n < 300) begin
      wr1_valid = (i1 < 3);
      wr1_data  = 8'h51 + 8'(i1);
      if (out_req && !ack_man) begin
        dly++;
        if (dly == 3) begin ack_man = 1'b1; dly = 0; end
      end else if (!out_req && ack_man) begin
        dly++;
        if (dly == 3) begin ack_man = 1'b0; dly = 0; end
      end else begin
        dly = 0;
      end
      #1;
      a1 = wr1_ready;
      tick();
      if (a1) i1++;
      n++;
    end
    wr1_valid = 1'b0;
    tests++; if (n >= 300) begin fails++; $display("FAIL slow_budget: got %0d cycles want < 300", n); end
    tests++; if (stab_err != s0) begin fails++; $display("FAIL slow_stable: got %0d changes want 0", stab_err - s0); end
    for (int k = 0; k < 3; k++) begin
      got_v = (base + k < obs.size()) ? obs[base + k] : 8'hxx;
      tests++; if (got_v !== 8'h51 + 8'(k)) begin fails++; $display("FAIL slow_order[%0d]: got %h want %h", k, got_v, 8'h51 + 8'(k)); end
    end
  endtask

  task automatic test_back_to_back();
    int i0 = 0;
    int n = 0;
    int base;
    logic a0;
    logic [WS-1:0] got_v;
    do_reset();
    ack_tie = 1'b1;
    base = obs.size();
    while (i0 < 4 && n < 50) begin
      wr0_valid = 1'b1;
      wr0_data  = 8'h10 + 8'(i0);
      #1;
      a0 = wr0_ready;
      tick();
      if (a0) i0++;
      n++;
    end
    wr0_valid = 1'b0;
    n = 0;
    while (obs.size() < base + 4 && n < 100) begin tick(); n++; end
    tests++; if (obs.size() != base + 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", obs.size() - base); end
    for (int k = 0; k < 4; k++) begin
      got_v = (base + k < obs.size()) ? obs[base + k] : 8'hxx;
      tests++; if (got_v !== 8'h10 + 8'(k)) begin fails++; $display("FAIL b2b_order[%0d]: got %h want %h", k, got_v, 8'h10 + 8'(k)); end
    end
    for (int k = 1; k < 4; k++) begin
      if (base + k < rise_q.size()) begin
        tests++; if (rise_q[base + k] - rise_q[base + k - 1] != 3) begin
          fails++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", k, rise_q[base + k] - rise_q[base + k - 1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_req();
    int n = 0;
    int base;
    do_reset();
    wr0_valid = 1'b1;
    wr0_data  = 8'h70;
    tick();
    wr0_data  = 8'h71;
    tick();
    wr0_valid = 1'b0;
    tests++; if (out_req !== 1'b1) begin fails++; $display("FAIL midreset_pre: got req=%b want 1", out_req); end
    rst_n     = 1'b0;
    wr0_valid = 1'b1;
    #1;
    tests++; if (out_req !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      fails++; $display("FAIL midreset_clear: got req=%b busy=%b data=%h want 0/0/00", out_req, busy, out_data);
    end
    tests++; if (wr0_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %b want 0", wr0_ready); end
    wr0_valid = 1'b0;
    repeat (2) tick();
    rst_n   = 1'b1;
    ack_tie = 1'b1;
    base    = obs.size();
    wr0_valid = 1'b1;
    wr0_data  = 8'h72;
    tick();
    wr0_valid = 1'b0;
    while ((busy || obs.size() < base + 1) && n < 50) begin tick(); n++; end
    repeat (3) tick();
    tests++; if (obs.size() != base + 1) begin fails++; $display("FAIL midreset_count: got %0d want 1", obs.size() - base); end
    tests++; if (obs.size() > base && obs[base] !== 8'h72) begin fails++; $display("FAIL midreset_word: got %h want 72", obs[base]); end
  endtask

`ifdef IO_OUT_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset();
    wr0_valid = 1'b1;
    wr0_data  = 8'h21;
    tick();
    wr0_data  = 8'h22;
    tick();
    wr0_valid = 1'b0;
    tests++; if (out_req !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL timeout_pre: got req=%b err=%b want 1/0", out_req, err);
    end
    while (out_req && n < 50) begin n++; tick(); end
    tests++; if (n != 8) begin fails++; $display("FAIL timeout_len: got %0d cycles want 8", n); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", err); end
    tick();
    tests++; if (out_req !== 1'b1 || out_data !== 8'h22) begin
      fails++; $display("FAIL timeout_next: got req=%b data=%h want 1/22", out_req, out_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_slow_device();
    test_back_to_back();
    test_reset_mid_req();
`ifdef IO_OUT_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
